// File: rtl/sum_accumulator_if.sv
// Beat/result handshake bundle for sum_accumulator: adder beats in, accumulated frame result out.
interface sum_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int BEATS     = 4
);
  localparam int CW = $clog2(BEATS + 1);

  logic [WIDTH-1:0]     i_Sum;
  logic                 i_Cout;
  logic                 i_Valid;
  logic                 o_Ready;
  logic                 i_Clear;
  logic [ACC_WIDTH-1:0] o_Acc;
  logic [CW-1:0]        o_Count;
  logic                 o_Ovf;
  logic                 o_Valid;
  logic                 i_Ready;

  modport slave (
    input  i_Sum, i_Cout, i_Valid, i_Clear, i_Ready,
    output o_Ready, o_Acc, o_Count, o_Ovf, o_Valid
  );

  modport master (
    output i_Sum, i_Cout, i_Valid, i_Clear, i_Ready,
    input  o_Ready, o_Acc, o_Count, o_Ovf, o_Valid
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates BEATS {carry,sum} beats into one result; o_Valid rises the cycle after the last beat and
// holds (o_Ready low) until i_Ready. SUM_ACC_SATURATE_EN clamps on overflow instead of wrapping.
module sum_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int BEATS     = 4
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  sum_accumulator_if.slave bus
);
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ready, w_ready_nxt;

  logic [ACC_WIDTH-1:0] w_beat;
  logic [ACC_WIDTH:0]   w_sum;
  logic [CW-1:0]        w_count_inc;
  logic                 w_accept;

  always_comb begin
    w_beat              = '0;
    w_beat[WIDTH:0]     = {bus.i_Cout, bus.i_Sum};
    w_sum               = {1'b0, r_acc} + {1'b0, w_beat};
    w_count_inc         = r_count + CW'(1);
    w_accept            = bus.i_Valid && r_ready;

    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_beat;
          w_count_nxt = CW'(1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = (BEATS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_count_nxt = w_count_inc;
          w_ovf_nxt   = r_ovf | w_sum[ACC_WIDTH];
`ifdef SUM_ACC_SATURATE_EN
          // once saturated the accumulator stays pinned for the rest of the frame
          w_acc_nxt   = (r_ovf || w_sum[ACC_WIDTH]) ? '1 : w_sum[ACC_WIDTH-1:0];
`else
          w_acc_nxt   = w_sum[ACC_WIDTH-1:0];
`endif
          if (w_count_inc == BEATS_C) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_Ready) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
        w_count_nxt = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase

    if (bus.i_Clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end

    // handshake outputs are registered copies of the next state
    w_ready_nxt = (w_state_nxt != DONE);
    w_valid_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= w_valid_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign bus.o_Acc   = r_acc;
  assign bus.o_Count = r_count;
  assign bus.o_Ovf   = r_ovf;
  assign bus.o_Valid = r_valid;
  assign bus.o_Ready = r_ready;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: three sum_accumulator instances (defaults, ACC_WIDTH=6, BEATS=1) share one stimulus.
module tb_sum_accumulator;
  logic       clk;
  logic       rst;
  logic [3:0] sum;
  logic       cout;
  logic       valid;
  logic       clear;
  logic       ready;

  int checks;
  int failures;

  sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(8), .BEATS(4)) ifa ();
  sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(6), .BEATS(4)) ifb ();
  sum_accumulator_if #(.WIDTH(4), .ACC_WIDTH(8), .BEATS(1)) ifc ();

  sum_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .BEATS(4)) dut_a (.i_Clk(clk), .i_Rst(rst), .bus(ifa));
  sum_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .BEATS(4)) dut_b (.i_Clk(clk), .i_Rst(rst), .bus(ifb));
  sum_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .BEATS(1)) dut_c (.i_Clk(clk), .i_Rst(rst), .bus(ifc));

  assign ifa.i_Sum = sum;  assign ifa.i_Cout = cout;  assign ifa.i_Valid = valid;
  assign ifa.i_Clear = clear;  assign ifa.i_Ready = ready;
  assign ifb.i_Sum = sum;  assign ifb.i_Cout = cout;  assign ifb.i_Valid = valid;
  assign ifb.i_Clear = clear;  assign ifb.i_Ready = ready;
  assign ifc.i_Sum = sum;  assign ifc.i_Cout = cout;  assign ifc.i_Valid = valid;
  assign ifc.i_Clear = clear;  assign ifc.i_Ready = ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] v);
    valid = 1'b1;
    {cout, sum} = v;
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; sum = '0; cout = 1'b0; valid = 1'b0; clear = 1'b0; ready = 1'b0;

    // reset between edges, before any clock edge has occurred
    #2 rst = 1'b1;
    #1;
    check("rst_acc",   32'(ifa.o_Acc),   32'h0);
    check("rst_count", 32'(ifa.o_Count), 32'h0);
    check("rst_ovf",   32'(ifa.o_Ovf),   32'h0);
    check("rst_valid", 32'(ifa.o_Valid), 32'h0);
    check("rst_ready", 32'(ifa.o_Ready), 32'h1);
    tick();
    rst = 1'b0;

    // four-beat frame 0x1F+0x10+0x05+0x03 = 0x37
    beat(5'h1F);
    check("f1_count1", 32'(ifa.o_Count), 32'h1);
    check("f1_valid1", 32'(ifa.o_Valid), 32'h0);
    beat(5'h10);
    beat(5'h05);
    check("f1_valid3", 32'(ifa.o_Valid), 32'h0);
    beat(5'h03);
    check("f1_acc",   32'(ifa.o_Acc),   32'h37);
    check("f1_count", 32'(ifa.o_Count), 32'h4);
    check("f1_ovf",   32'(ifa.o_Ovf),   32'h0);
    check("f1_valid", 32'(ifa.o_Valid), 32'h1);
    check("f1_ready", 32'(ifa.o_Ready), 32'h0);

    // backpressure: hold DONE three cycles with beats offered
    valid = 1'b1; {cout, sum} = 5'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_acc",   32'(ifa.o_Acc),   32'h37);
      check("bp_count", 32'(ifa.o_Count), 32'h4);
      check("bp_ready", 32'(ifa.o_Ready), 32'h0);
      check("bp_valid", 32'(ifa.o_Valid), 32'h1);
    end
    valid = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    check("rel_valid", 32'(ifa.o_Valid), 32'h0);
    check("rel_acc",   32'(ifa.o_Acc),   32'h0);
    check("rel_count", 32'(ifa.o_Count), 32'h0);
    check("rel_ready", 32'(ifa.o_Ready), 32'h1);

    // clear beats a simultaneous valid beat
    pulse_reset();
    beat(5'h02);
    beat(5'h03);
    check("clr_pre_acc", 32'(ifa.o_Acc), 32'h5);
    clear = 1'b1;
    beat(5'h04);
    clear = 1'b0;
    check("clr_acc",   32'(ifa.o_Acc),   32'h0);
    check("clr_count", 32'(ifa.o_Count), 32'h0);
    check("clr_valid", 32'(ifa.o_Valid), 32'h0);
    check("clr_ready", 32'(ifa.o_Ready), 32'h1);
    beat(5'h06);
    check("clr_new_acc",   32'(ifa.o_Acc),   32'h6);
    check("clr_new_count", 32'(ifa.o_Count), 32'h1);

    // async reset mid-frame takes effect without a clock
    beat(5'h01);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_acc",   32'(ifa.o_Acc),   32'h0);
    check("mid_rst_count", 32'(ifa.o_Count), 32'h0);
    check("mid_rst_ready", 32'(ifa.o_Ready), 32'h1);
    rst = 1'b0;
    beat(5'h01);
    check("post_rst_count", 32'(ifa.o_Count), 32'h1);
    check("post_rst_acc",   32'(ifa.o_Acc),   32'h1);

    // overflow on the 6-bit accumulator: 31+31+31 = 93 exceeds 63
    pulse_reset();
    beat(5'h1F);
    beat(5'h1F);
    check("ovf_b_pre", 32'(ifb.o_Ovf), 32'h0);
    beat(5'h1F);
    check("ovf_b_ovf3", 32'(ifb.o_Ovf), 32'h1);
`ifdef SUM_ACC_SATURATE_EN
    check("ovf_b_acc3", 32'(ifb.o_Acc), 32'h3F);
`else
    check("ovf_b_acc3", 32'(ifb.o_Acc), 32'h1D);
`endif
    beat(5'h1F);
`ifdef SUM_ACC_SATURATE_EN
    check("ovf_b_acc", 32'(ifb.o_Acc), 32'h3F);
`else
    check("ovf_b_acc", 32'(ifb.o_Acc), 32'h3C);
`endif
    check("ovf_b_ovf",   32'(ifb.o_Ovf),   32'h1);
    check("ovf_b_valid", 32'(ifb.o_Valid), 32'h1);
    check("ovf_a_acc",   32'(ifa.o_Acc),   32'h7C);
    check("ovf_a_ovf",   32'(ifa.o_Ovf),   32'h0);

    // clear out of DONE wins over i_Ready and drops the sticky flag
    clear = 1'b1; ready = 1'b1;
    tick();
    clear = 1'b0; ready = 1'b0;
    check("done_clr_valid", 32'(ifb.o_Valid), 32'h0);
    check("done_clr_ovf",   32'(ifb.o_Ovf),   32'h0);
    check("done_clr_acc",   32'(ifb.o_Acc),   32'h0);

    // single-beat frames
    pulse_reset();
    beat(5'h12);
    check("b1_valid", 32'(ifc.o_Valid), 32'h1);
    check("b1_acc",   32'(ifc.o_Acc),   32'h12);
    check("b1_count", 32'(ifc.o_Count), 32'h1);
    beat(5'h07);
    check("b1_hold_acc", 32'(ifc.o_Acc), 32'h12);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("b1_rel_valid", 32'(ifc.o_Valid), 32'h0);
    check("b1_rel_acc",   32'(ifc.o_Acc),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the adder operand/sum width of each incoming beat.
REQ-002 SHALL have parameter ACC_WIDTH, default 8, the accumulator width; legal only when ACC_WIDTH >= WIDTH+1.
REQ-003 SHALL have parameter BEATS, default 4, the number of beats per result; legal only when BEATS >= 1.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports named i_Clk and i_Rst.
REQ-005 Ports (CW = $clog2(BEATS+1)):
- i_Clk  in  1  clock.
- i_Rst  in  1  async active-high reset.
- i_Sum  in  WIDTH  adder sum for this beat.
- i_Cout  in  1  adder carry for this beat.
- i_Valid  in  1  beat present.
- o_Ready  out  1  beat accepted when i_Valid && o_Ready.
- i_Clear  in  1  synchronous abort/clear.
- o_Acc  out  ACC_WIDTH  accumulated result.
- o_Count  out  CW  beats accepted in the current frame.
- o_Ovf  out  1  sticky accumulator overflow.
- o_Valid  out  1  result available.
- i_Ready  in  1  result consumed when o_Valid && i_Ready.

Function
REQ-006 Beat value SHALL be {i_Cout, i_Sum} zero-extended to ACC_WIDTH.
REQ-007 FSM SHALL have states IDLE, ACCUM, DONE; all outputs registered.
REQ-008 IDLE: o_Ready=1, o_Valid=0; on accepted beat, acc<=beat, count<=1; next state DONE if BEATS==1, else ACCUM.
REQ-009 ACCUM: o_Ready=1; each accepted beat adds to acc and increments count; the beat making count==BEATS moves to DONE; no beat = hold.
REQ-010 DONE: o_Ready=0, o_Valid=1; o_Acc, o_Count, o_Ovf held stable; i_Valid ignored.
REQ-011 DONE with i_Ready=1 SHALL go to IDLE next cycle with acc, count, ovf cleared to 0.
REQ-012 Latency: o_Valid SHALL rise the cycle after the final beat is accepted; no combinational path from any input to any output.
REQ-013 Overflow: a carry out of ACC_WIDTH bits on any add SHALL set o_Ovf until the frame ends; acc wraps modulo 2^ACC_WIDTH (unless REQ-018).
REQ-014 i_Clear=1 SHALL, next edge, force IDLE and zero acc, count, ovf, o_Valid from any state; clear beats a simultaneous valid beat or i_Ready (beat dropped, result discarded).

Reset
REQ-015 i_Rst=1 SHALL immediately, without a clock, force IDLE, o_Acc=0, o_Count=0, o_Ovf=0, o_Valid=0, o_Ready=1.
REQ-016 Reset asserted mid-ACCUM or in DONE SHALL discard the partial/pending result; first beat after release starts a new frame.

Configuration
REQ-017 Macro SUM_ACC_SATURATE_EN SHALL select overflow handling.
REQ-018 With SUM_ACC_SATURATE_EN defined: on overflow acc SHALL clamp to all-ones and stay there for the frame; o_Ovf still set. Without it: wrap per REQ-013.

Verification
REQ-019 Reset: assert i_Rst between edges -> outputs zero and o_Ready=1 immediately, no clock needed.
REQ-020 Defaults; beats {Cout,Sum}=0x1F,0x10,0x05,0x03 -> o_Acc=0x37, o_Count=4, o_Ovf=0, o_Valid=1 the cycle after 4th beat.
REQ-021 Backpressure: in DONE hold i_Ready=0 three cycles with i_Valid=1 -> o_Acc stable, o_Ready=0, no beat counted; i_Ready=1 -> IDLE, o_Acc=0 next cycle.
REQ-022 ACC_WIDTH=6; four beats 0x1F -> o_Acc=0x3C, o_Ovf=1 without macro; o_Acc=0x3F, o_Ovf=1 with SUM_ACC_SATURATE_EN.
REQ-023 After two beats, i_Clear=1 and i_Valid=1 same cycle -> IDLE, o_Acc=0, o_Count=0; beat not counted.
REQ-024 BEATS=1: single beat 0x12 -> o_Valid=1, o_Acc=0x12, o_Count=1 next cycle.
